// File: rtl/video_tpg_multi.sv
// video_tpg_multi
//   Video test-pattern memory responder. Sits in place of video RAM on the
//   frame-buffer read path. Each accepted read request gets synthetic pixel data
//   (RGB555, one pixel per 16-bit lane). Responses are queued and returned in
//   request order after a configurable latency.
//
//   Build option: define VIDEO_TPG_JITTER_EN to add LFSR-driven latency jitter
//   (lat = MIN_LAT + (lfsr[3:0] & JMASK)). Without it lat = MIN_LAT exactly.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   en           1 = pattern data, 0 = zero data (acks still returned)
//   vsync        rising edge starts a frame (reseed LFSR, frame+1, latch mode)
//   mode         pattern select: 0 gradient, 1 colour bars, 2 checker, 3 noise
//   req_cyc      read request valid; req_tid / req_adr held while stalled
//   req_stall    queue full, request not accepted this cycle
//   resp_ack     one-cycle response strobe per request
//   resp_tid     echoed transaction id
//   resp_adr     echoed byte address
//   resp_dat     pattern data, lane k in resp_dat[16k+15:16k]
module video_tpg_multi #(
  parameter int unsigned DAT_W   = 256,
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned TID_W   = 13,
  parameter int unsigned HRES    = 800,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MIN_LAT = 2,
  parameter int unsigned JMASK   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             vsync,
  input  logic [1:0]       mode,
  input  logic             req_cyc,
  input  logic [TID_W-1:0] req_tid,
  input  logic [ADR_W-1:0] req_adr,
  output logic             req_stall,
  output logic             resp_ack,
  output logic [TID_W-1:0] resp_tid,
  output logic [ADR_W-1:0] resp_adr,
  output logic [DAT_W-1:0] resp_dat
);

  localparam int unsigned LANES = DAT_W / 16;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef VIDEO_TPG_JITTER_EN
  localparam int unsigned JITTER_ON = 1;
`else
  localparam int unsigned JITTER_ON = 0;
`endif
  // Mask collapses to zero when jitter is not built in.
  localparam logic [3:0] JMASK_EFF = 4'(JMASK * JITTER_ON);

  // Frame / pattern state
  logic             vsync_q;
  logic [4:0]       frame;
  logic [1:0]       mode_q;
  logic [30:0]      lfsr;
  logic [30:0]      lfsr_next;
  logic [7:0]       timer;

  // Response queue
  logic [DAT_W-1:0] q_dat [DEPTH];
  logic [TID_W-1:0] q_tid [DEPTH];
  logic [ADR_W-1:0] q_adr [DEPTH];
  logic [7:0]       q_due [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_n;

  logic             accept;
  logic             pop;
  logic             vs_rise;
  logic [7:0]       lat;
  logic [7:0]       late;

  // Pixel generation scratch
  logic [DAT_W-1:0] pix_dat;
  logic [ADR_W-1:0] pix_n;
  logic [ADR_W-1:0] x0;
  logic [ADR_W-1:0] y0;
  logic [ADR_W-1:0] xs;
  logic [ADR_W-1:0] x;
  logic [4:0]       y;
  logic [2:0]       bar;
  logic [15:0]      lane;

  // Handshake, pop decision and occupancy
  always_comb begin
    accept    = req_cyc & ~req_stall;
    vs_rise   = vsync & ~vsync_q;
    lfsr_next = {lfsr[29:0], lfsr[30] ^ lfsr[27]};
    lat       = 8'(MIN_LAT) + 8'(lfsr[3:0] & JMASK_EFF);
    // Head is due once (timer - due) is non-negative as an 8-bit signed value.
    late      = timer - q_due[rd_ptr];
    pop       = (count != '0) && !late[7];
    count_n   = count + CNT_W'(accept) - CNT_W'(pop);
  end

  // Pattern data for all lanes of the incoming request
  always_comb begin
    pix_dat = '0;
    pix_n   = req_adr >> 1;
    x0      = ADR_W'(pix_n % ADR_W'(HRES));
    y0      = ADR_W'(pix_n / ADR_W'(HRES));
    xs      = '0;
    x       = '0;
    y       = '0;
    bar     = '0;
    lane    = '0;
    for (int k = 0; k < LANES; k++) begin
      // Lane offset may carry the pixel into the next scan line.
      xs  = x0 + ADR_W'(k);
      x   = ADR_W'(xs % ADR_W'(HRES));
      y   = 5'(y0 + ADR_W'(xs / ADR_W'(HRES)));
      bar = 3'((x << 3) / ADR_W'(HRES));
      lane = '0;
      case (mode_q)
        2'd0: lane = {1'b0, frame, y, x[4:0]};
        2'd1: lane = {1'b0, {5{bar[2]}}, {5{bar[1]}}, {5{bar[0]}}};
        2'd2: lane = (x[3] ^ y[3]) ? 16'h7FFF : 16'h0000;
        2'd3: lane = {1'b0, lfsr[14:0] ^ 15'(k)};
        default: lane = '0;
      endcase
      if (!en) lane = '0;
      pix_dat[16*k +: 16] = lane;
    end
  end

  // Queue storage, written at accept only
  always_ff @(posedge clk) begin
    if (accept) begin
      q_dat[wr_ptr] <= pix_dat;
      q_tid[wr_ptr] <= req_tid;
      q_adr[wr_ptr] <= req_adr;
      q_due[wr_ptr] <= timer + lat;
    end
  end

  // Control state, pointers and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      frame     <= '0;
      mode_q    <= '0;
      lfsr      <= 31'h1;
      timer     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_stall <= 1'b0;
      resp_ack  <= 1'b0;
      resp_tid  <= '0;
      resp_adr  <= '0;
      resp_dat  <= '0;
    end else begin
      vsync_q   <= vsync;
      timer     <= timer + 8'd1;
      count     <= count_n;
      req_stall <= (count_n == CNT_W'(DEPTH));
      if (vs_rise) begin
        lfsr   <= 31'h1;
        frame  <= frame + 5'd1;
        mode_q <= mode;
      end else if (accept) begin
        lfsr   <= lfsr_next;
      end
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        resp_ack <= 1'b1;
        resp_tid <= q_tid[rd_ptr];
        resp_adr <= q_adr[rd_ptr];
        resp_dat <= q_dat[rd_ptr];
      end else begin
        resp_ack <= 1'b0;
      end
    end
  end

endmodule
